// File: rtl/xcvr_652_sync.sv
// xcvr_652_sync: registered bidirectional bus transceiver (74S652-style) with full/overrun handshake.
// Optional XCVR_PARITY_EN adds odd parity on b_out and a parity-error flag on reg_ab loads.
`default_nettype none

module xcvr_652_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cab,
  input  logic         cba,
  input  logic         sab,
  input  logic         sba,
  input  logic         oeab,
  input  logic         oeba_n,
  input  logic         ab_ack,
  input  logic         ba_ack,
  input  logic         clr_ovr,
  output logic [W-1:0] b_out,
  output logic         b_oe,
  output logic [W-1:0] a_out,
  output logic         a_oe,
  output logic         ab_full,
  output logic         ba_full,
  output logic         ab_ovr,
  output logic         ba_ovr
`ifdef XCVR_PARITY_EN
  ,
  output logic         b_par,
  output logic         ab_perr
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t       ab_st_q, ab_st_d;
  state_t       ba_st_q, ba_st_d;
  logic [W-1:0] reg_ab_q, reg_ab_d;
  logic [W-1:0] reg_ba_q, reg_ba_d;
  logic         ab_ovr_q, ab_ovr_d;
  logic         ba_ovr_q, ba_ovr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_st_q  <= ST_EMPTY;
      ba_st_q  <= ST_EMPTY;
      reg_ab_q <= '0;
      reg_ba_q <= '0;
      ab_ovr_q <= 1'b0;
      ba_ovr_q <= 1'b0;
    end else begin
      ab_st_q  <= ab_st_d;
      ba_st_q  <= ba_st_d;
      reg_ab_q <= reg_ab_d;
      reg_ba_q <= reg_ba_d;
      ab_ovr_q <= ab_ovr_d;
      ba_ovr_q <= ba_ovr_d;
    end
  end

  // A load while FULL without a matching ack loses data; set beats clr_ovr.
  always_comb begin
    ab_st_d  = ab_st_q;
    reg_ab_d = reg_ab_q;
    ab_ovr_d = ab_ovr_q & ~clr_ovr;
    if (cab) reg_ab_d = a_in;
    case (ab_st_q)
      ST_EMPTY: if (cab) ab_st_d = ST_FULL;
      ST_FULL: begin
        if (cab) begin
          if (!ab_ack) ab_ovr_d = 1'b1;
        end else if (ab_ack) begin
          ab_st_d = ST_EMPTY;
        end
      end
      default: ab_st_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    ba_st_d  = ba_st_q;
    reg_ba_d = reg_ba_q;
    ba_ovr_d = ba_ovr_q & ~clr_ovr;
    if (cba) reg_ba_d = b_in;
    case (ba_st_q)
      ST_EMPTY: if (cba) ba_st_d = ST_FULL;
      ST_FULL: begin
        if (cba) begin
          if (!ba_ack) ba_ovr_d = 1'b1;
        end else if (ba_ack) begin
          ba_st_d = ST_EMPTY;
        end
      end
      default: ba_st_d = ST_EMPTY;
    endcase
  end

  assign b_out   = sab ? reg_ab_q : a_in;
  assign a_out   = sba ? reg_ba_q : b_in;
  assign b_oe    = oeab;
  assign a_oe    = ~oeba_n;
  assign ab_full = (ab_st_q == ST_FULL);
  assign ba_full = (ba_st_q == ST_FULL);
  assign ab_ovr  = ab_ovr_q;
  assign ba_ovr  = ba_ovr_q;

`ifdef XCVR_PARITY_EN
  logic ab_perr_q, ab_perr_d;

  always_comb begin
    ab_perr_d = ab_perr_q & ~clr_ovr;
    if (cab && !(^a_in)) ab_perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ab_perr_q <= 1'b0;
    else       ab_perr_q <= ab_perr_d;
  end

  assign b_par   = ~(^b_out);
  assign ab_perr = ab_perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xcvr_652_sync.sv
// tb_xcvr_652_sync: directed plus randomized checks of xcvr_652_sync against a behavioural model.
`default_nettype none

module tb_xcvr_652_sync;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_in, b_in;
  logic         cab, cba, sab, sba, oeab, oeba_n, ab_ack, ba_ack, clr_ovr;
  logic [W-1:0] b_out, a_out;
  logic         b_oe, a_oe, ab_full, ba_full, ab_ovr, ba_ovr;
`ifdef XCVR_PARITY_EN
  logic         b_par, ab_perr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [W-1:0] m_ab, m_ba;
  logic         m_ab_full, m_ba_full, m_ab_ovr, m_ba_ovr, m_perr;

  xcvr_652_sync #(.W(W)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .cab(cab), .cba(cba), .sab(sab), .sba(sba),
    .oeab(oeab), .oeba_n(oeba_n), .ab_ack(ab_ack), .ba_ack(ba_ack),
    .clr_ovr(clr_ovr), .b_out(b_out), .b_oe(b_oe), .a_out(a_out), .a_oe(a_oe),
    .ab_full(ab_full), .ba_full(ba_full), .ab_ovr(ab_ovr), .ba_ovr(ba_ovr)
`ifdef XCVR_PARITY_EN
    , .b_par(b_par), .ab_perr(ab_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_ab = '0; m_ba = '0;
    m_ab_full = 0; m_ba_full = 0; m_ab_ovr = 0; m_ba_ovr = 0; m_perr = 0;
  endtask

  // One direction's effect of a clock edge, from the handshake rules.
  task automatic model_dir(input logic load, input logic ack, input logic [W-1:0] din,
                           inout logic [W-1:0] r, inout logic full, inout logic ovr);
    logic lost;
    lost = full && load && !ack;
    if (lost)         ovr = 1'b1;
    else if (clr_ovr) ovr = 1'b0;
    if (load)         full = 1'b1;
    else if (ack)     full = 1'b0;
    if (load)         r = din;
  endtask

  task automatic tick();
    @(posedge clk);
    if (cab && (ones(a_in) % 2 == 0)) m_perr = 1'b1;
    else if (clr_ovr)                  m_perr = 1'b0;
    model_dir(cab, ab_ack, a_in, m_ab, m_ab_full, m_ab_ovr);
    model_dir(cba, ba_ack, b_in, m_ba, m_ba_full, m_ba_ovr);
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, ".b_out"},   b_out,   sab ? m_ab : a_in);
    check({tag, ".a_out"},   a_out,   sba ? m_ba : b_in);
    check({tag, ".b_oe"},    b_oe,    oeab);
    check({tag, ".a_oe"},    a_oe,    !oeba_n);
    check({tag, ".ab_full"}, ab_full, m_ab_full);
    check({tag, ".ba_full"}, ba_full, m_ba_full);
    check({tag, ".ab_ovr"},  ab_ovr,  m_ab_ovr);
    check({tag, ".ba_ovr"},  ba_ovr,  m_ba_ovr);
`ifdef XCVR_PARITY_EN
    check({tag, ".b_par"},   b_par,   (ones(sab ? m_ab : a_in) % 2 == 0));
    check({tag, ".ab_perr"}, ab_perr, m_perr);
`endif
  endtask

  task automatic idle_inputs();
    cab = 0; cba = 0; ab_ack = 0; ba_ack = 0; clr_ovr = 0;
  endtask

  initial begin
    reset = 0; a_in = '0; b_in = '0; sab = 1; sba = 1; oeab = 0; oeba_n = 1;
    idle_inputs();
    model_reset();
    #2 reset = 1;
    #1;
    check("rst.ab_full", ab_full, 0);
    check("rst.ba_full", ba_full, 0);
    check("rst.ab_ovr", ab_ovr, 0);
    check("rst.ba_ovr", ba_ovr, 0);
    check("rst.b_out", b_out, 8'h00);
    check("rst.a_out", a_out, 8'h00);
    @(negedge clk) reset = 0;
    tick();

    // Real-time path
    sab = 0; a_in = 8'hA5; oeab = 1; oeba_n = 1;
    #1;
    check("rt.b_out", b_out, 8'hA5);
    check("rt.b_oe", b_oe, 1);
    check("rt.a_oe", a_oe, 0);

    // Store and hold
    a_in = 8'h3C; cab = 1;
    tick();
    cab = 0; a_in = 8'hFF; sab = 1;
    #1;
    check("store.b_out", b_out, 8'h3C);
    check("store.ab_full", ab_full, 1);
    ab_ack = 1;
    tick();
    ab_ack = 0;
    #1;
    check("ack.ab_full", ab_full, 0);
    check("ack.b_out", b_out, 8'h3C);
    check("ack.ab_ovr", ab_ovr, 0);

    // Ack while empty is ignored
    ab_ack = 1;
    tick();
    ab_ack = 0;
    check_all("ack_empty");

    // Overrun sequence
    a_in = 8'h55; cab = 1;
    tick();
    a_in = 8'h11;
    tick();
    cab = 0;
    #1;
    check("ovr.ab_ovr", ab_ovr, 1);
    check("ovr.b_out", b_out, 8'h11);
    a_in = 8'h22; cab = 1; ab_ack = 1;
    tick();
    cab = 0; ab_ack = 0;
    #1;
    check("ldack.ab_full", ab_full, 1);
    check("ldack.b_out", b_out, 8'h22);
    check("ldack.ab_ovr", ab_ovr, 1);
    clr_ovr = 1;
    tick();
    clr_ovr = 0;
    #1;
    check("clr.ab_ovr", ab_ovr, 0);

    // Clear coinciding with a new overrun: set wins
    a_in = 8'h33; cab = 1; clr_ovr = 1;
    tick();
    idle_inputs();
    #1;
    check("setwins.ab_ovr", ab_ovr, 1);

    // Independence and simultaneity, then async reset mid-cycle
    a_in = 8'h0F; b_in = 8'hF0; cab = 1; cba = 1; sab = 1; sba = 1;
    tick();
    idle_inputs();
    #1;
    check("sim.b_out", b_out, 8'h0F);
    check("sim.a_out", a_out, 8'hF0);
    check("sim.ab_full", ab_full, 1);
    check("sim.ba_full", ba_full, 1);
    #1 reset = 1;
    #1;
    model_reset();
    check("midrst.b_out", b_out, 8'h00);
    check("midrst.a_out", a_out, 8'h00);
    check("midrst.ab_full", ab_full, 0);
    check("midrst.ba_full", ba_full, 0);
    check("midrst.ab_ovr", ab_ovr, 0);
    reset = 0;
    tick();

`ifdef XCVR_PARITY_EN
    sab = 0; a_in = 8'h03;
    #1;
    check("par.b_par", b_par, 1);
    cab = 1;
    tick();
    cab = 0;
    #1;
    check("par.ab_perr_set", ab_perr, 1);
    clr_ovr = 1;
    tick();
    clr_ovr = 0; a_in = 8'h07; cab = 1;
    tick();
    cab = 0;
    #1;
    check("par.ab_perr_clr", ab_perr, 0);
`endif

    // Randomized traffic; real-time loopback avoided since the bench drives both buses
    for (int n = 0; n < 400; n++) begin
      a_in    = W'($urandom);
      b_in    = W'($urandom);
      cab     = ($urandom_range(0, 2) == 0);
      cba     = ($urandom_range(0, 2) == 0);
      ab_ack  = ($urandom_range(0, 2) == 0);
      ba_ack  = ($urandom_range(0, 2) == 0);
      clr_ovr = ($urandom_range(0, 5) == 0);
      sab     = W'($urandom) > 8'd100;
      sba     = W'($urandom) > 8'd100;
      oeab    = $urandom_range(0, 1) == 1;
      oeba_n  = $urandom_range(0, 1) == 1;
      check_all("rnd");
      if ($urandom_range(0, 49) == 0) begin
        reset = 1;
        #1;
        model_reset();
        check_all("rnd_rst");
        reset = 0;
      end
      tick();
    end
    idle_inputs();
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
